mor1kx_pcu_sampler: RTL and testbench

//  SPR-bus initiator that snapshots the performance counter unit. On a periodic tick or manual trigger,

---
 rtl/mor1kx_pcu_sampler_pkg.sv | 27 ++
 rtl/mor1kx_pcu_sample_fifo.sv | 65 ++++++
 rtl/mor1kx_pcu_sampler.sv | 179 +++++++++++++++++
 tb/tb_mor1kx_pcu_sampler.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mor1kx_pcu_sampler_pkg.sv
// rtl/mor1kx_pcu_sampler_pkg.sv - shared types and constants for the PCU sampler
// Purpose: sample record layout, default PCCR0 SPR address, record packing helper.
// Ports: none (package).
package mor1kx_pcu_sampler_pkg;

  // SPR group 7 (performance counters), register 0.
  localparam logic [15:0] PCCR0_ADDR = 16'h3800;

  typedef struct packed {
    logic        last;
    logic [2:0]  idx;
    logic [31:0] data;
  } sample_t;

  localparam int SMP_W = $bits(sample_t);

  function automatic sample_t pack_sample(input logic [2:0] idx,
                                          input logic [31:0] data,
                                          input logic last);
    sample_t s;
    s.last = last;
    s.idx  = idx;
    s.data = data;
    return s;
  endfunction

endpackage

// File: rtl/mor1kx_pcu_sample_fifo.sv
// rtl/mor1kx_pcu_sample_fifo.sv - synchronous sample FIFO with free-entry count
// Purpose: buffers {last, idx, data} samples between the burst FSM and the consumer.
// Ports:
//   clk, rst        clock, synchronous active-high reset (flushes the FIFO)
//   push, push_data write side; a push while full is accepted only with a pop
//   pop, pop_data   read side; pop_data is the head entry, 0 when empty
//   empty           no entries held
//   free            number of unused entries
module mor1kx_pcu_sample_fifo
  import mor1kx_pcu_sampler_pkg::*;
#(
  parameter int W     = SMP_W,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [W-1:0]               push_data,
  input  logic                       pop,
  output logic [W-1:0]               pop_data,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     free
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          full;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == DEPTH_C);
  assign free    = DEPTH_C - count;
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Head is masked while empty so the outputs read 0 after a flush.
  assign pop_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mor1kx_pcu_sampler.sv
// rtl/mor1kx_pcu_sampler.sv - SPR-bus initiator snapshotting the performance counters
// Purpose: on a periodic tick or manual trigger, reads PCCR0..PCCRn (optionally
// clearing each after the read) and streams {index, value} samples through a FIFO.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   sample_en_i, period_i         periodic timer enable and reload (0 = off)
//   trigger_i                     one-cycle manual burst request
//   clear_on_read_i               write 0 after each read, latched at burst start
//   spr_grant_i                   arbiter grant
//   spr_access_o/we_o/re_o        registered SPR strobes
//   spr_addr_o, spr_dat_o         SPR address, write data (always 0)
//   spr_ack_i, spr_dat_i          responder ack and read data
//   smp_valid_o/ready_i           sample handshake
//   smp_index_o/data_o/last_o     head sample fields
//   skipped_o                     sticky: a burst was dropped for lack of FIFO room
//   busy_o                        burst in progress
module mor1kx_pcu_sampler
  import mor1kx_pcu_sampler_pkg::*;
#(
  parameter int          OPTION_PERFCOUNTERS_NUM = 7,
  parameter int          FIFO_DEPTH              = 16,
  parameter logic [15:0] PCCR_BASE_ADDR          = PCCR0_ADDR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sample_en_i,
  input  logic [31:0] period_i,
  input  logic        trigger_i,
  input  logic        clear_on_read_i,
  input  logic        spr_grant_i,
  output logic        spr_access_o,
  output logic        spr_we_o,
  output logic        spr_re_o,
  output logic [15:0] spr_addr_o,
  output logic [31:0] spr_dat_o,
  input  logic        spr_ack_i,
  input  logic [31:0] spr_dat_i,
  output logic        smp_valid_o,
  input  logic        smp_ready_i,
  output logic [2:0]  smp_index_o,
  output logic [31:0] smp_data_o,
  output logic        smp_last_o,
  output logic        skipped_o,
  output logic        busy_o
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RD   = 2'd1;
  localparam logic [1:0] ST_CLR  = 2'd2;
  localparam logic [1:0] ST_PUSH = 2'd3;

  localparam int            FW        = $clog2(FIFO_DEPTH) + 1;
  localparam logic [FW-1:0] BURST_LEN = FW'(OPTION_PERFCOUNTERS_NUM + 1);
  localparam logic [2:0]    LAST_IDX  = 3'(OPTION_PERFCOUNTERS_NUM);

  logic [1:0]    state;
  logic [2:0]    idx;
  logic          clr_q;
  logic [31:0]   rd_data;
  logic [31:0]   timer;
  logic          run;
  logic          run_q;
  logic          tick;
  logic          pending;
  logic          skipped;
  logic          xfer;
  logic [FW-1:0] fifo_free;
  logic          fifo_empty;
  sample_t       head;

  assign run  = sample_en_i && (period_i != '0);
  // The enabling cycle only loads the timer, so the first tick lands period+1 cycles later.
  assign tick = run && run_q && (timer == '0);
  // An ack without grant belongs to another master's access.
  assign xfer = spr_grant_i && spr_ack_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      timer <= '0;
      run_q <= 1'b0;
    end else begin
      run_q <= run;
      if (!run)
        timer <= '0;
      else if (!run_q || timer == '0)
        timer <= period_i;
      else
        timer <= timer - 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      pending      <= 1'b0;
      skipped      <= 1'b0;
      idx          <= '0;
      clr_q        <= 1'b0;
      rd_data      <= '0;
      spr_access_o <= 1'b0;
      spr_re_o     <= 1'b0;
      spr_we_o     <= 1'b0;
      spr_addr_o   <= '0;
    end else begin
      // A request held while idle is consumed this cycle (started or dropped).
      pending <= (pending && state != ST_IDLE) || tick || trigger_i;
      case (state)
        ST_IDLE: begin
          if (pending) begin
            if (fifo_free >= BURST_LEN) begin
              state        <= ST_RD;
              clr_q        <= clear_on_read_i;
              idx          <= '0;
              spr_access_o <= 1'b1;
              spr_re_o     <= 1'b1;
              spr_addr_o   <= PCCR_BASE_ADDR;
            end else begin
              skipped <= 1'b1;
            end
          end
        end
        ST_RD: begin
          if (xfer) begin
            rd_data  <= spr_dat_i;
            spr_re_o <= 1'b0;
            if (clr_q) begin
              state    <= ST_CLR;
              spr_we_o <= 1'b1;
            end else begin
              state        <= ST_PUSH;
              spr_access_o <= 1'b0;
            end
          end
        end
        ST_CLR: begin
          if (xfer) begin
            state        <= ST_PUSH;
            spr_access_o <= 1'b0;
            spr_we_o     <= 1'b0;
          end
        end
        default: begin
          if (idx == LAST_IDX) begin
            state <= ST_IDLE;
          end else begin
            state        <= ST_RD;
            idx          <= idx + 3'd1;
            spr_access_o <= 1'b1;
            spr_re_o     <= 1'b1;
            spr_addr_o   <= PCCR_BASE_ADDR + {13'd0, idx + 3'd1};
          end
        end
      endcase
    end
  end

  mor1kx_pcu_sample_fifo #(
    .W     (SMP_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (state == ST_PUSH),
    .push_data (pack_sample(idx, rd_data, idx == LAST_IDX)),
    .pop       (smp_ready_i),
    .pop_data  (head),
    .empty     (fifo_empty),
    .free      (fifo_free)
  );

  assign spr_dat_o   = '0;
  assign smp_valid_o = !fifo_empty;
  assign smp_index_o = head.idx;
  assign smp_data_o  = head.data;
  assign smp_last_o  = head.last;
  assign skipped_o   = skipped;
  assign busy_o      = (state != ST_IDLE);

endmodule

// File: tb/tb_mor1kx_pcu_sampler.sv
// tb/tb_mor1kx_pcu_sampler.sv - self-checking bench for mor1kx_pcu_sampler
module tb_mor1kx_pcu_sampler;

  localparam logic [15:0] BASE = 16'h3800;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sample_en_i = 1'b0;
  logic [31:0] period_i = '0;
  logic        trigger_i = 1'b0;
  logic        clear_on_read_i = 1'b0;
  logic        spr_grant_i = 1'b1;
  logic        spr_access_o;
  logic        spr_we_o;
  logic        spr_re_o;
  logic [15:0] spr_addr_o;
  logic [31:0] spr_dat_o;
  logic        spr_ack_i;
  logic [31:0] spr_dat_i;
  logic        smp_valid_o;
  logic        smp_ready_i = 1'b1;
  logic [2:0]  smp_index_o;
  logic [31:0] smp_data_o;
  logic        smp_last_o;
  logic        skipped_o;
  logic        busy_o;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Responder model state
  logic [31:0] pccr [8];
  logic [31:0] load_base = '0;
  logic        load_req  = 1'b0;
  int          ack_delay = 0;
  int          acc_cnt   = 0;
  logic [15:0] roff;

  // Scoreboard / monitor state
  logic [35:0] exp_q [$];
  int          rise_cyc [$];
  int          n_rd = 0;
  int          n_wr = 0;
  logic [15:0] last_rd_addr = '0;
  logic        busy_prev = 1'b0;

  mor1kx_pcu_sampler dut (
    .clk             (clk),
    .rst             (rst),
    .sample_en_i     (sample_en_i),
    .period_i        (period_i),
    .trigger_i       (trigger_i),
    .clear_on_read_i (clear_on_read_i),
    .spr_grant_i     (spr_grant_i),
    .spr_access_o    (spr_access_o),
    .spr_we_o        (spr_we_o),
    .spr_re_o        (spr_re_o),
    .spr_addr_o      (spr_addr_o),
    .spr_dat_o       (spr_dat_o),
    .spr_ack_i       (spr_ack_i),
    .spr_dat_i       (spr_dat_i),
    .smp_valid_o     (smp_valid_o),
    .smp_ready_i     (smp_ready_i),
    .smp_index_o     (smp_index_o),
    .smp_data_o      (smp_data_o),
    .smp_last_o      (smp_last_o),
    .skipped_o       (skipped_o),
    .busy_o          (busy_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Responder: ack after ack_delay cycles of access; data only valid on a granted ack.
  always_comb begin
    roff      = spr_addr_o - BASE;
    spr_ack_i = spr_access_o && (acc_cnt >= ack_delay);
    spr_dat_i = (spr_ack_i && spr_grant_i) ? pccr[roff[2:0]] : 32'hBAD0BAD0;
  end

  always @(posedge clk) begin
    if (rst || !spr_access_o || (spr_grant_i && spr_ack_i))
      acc_cnt <= 0;
    else
      acc_cnt <= acc_cnt + 1;
    if (load_req) begin
      for (int i = 0; i < 8; i++) pccr[i] <= load_base + 32'(i);
    end else if (spr_access_o && spr_we_o && spr_grant_i && spr_ack_i) begin
      pccr[roff[2:0]] <= '0;
    end
  end

  // Monitor: scoreboard pops, SPR transfer accounting, burst start times.
  always @(negedge clk) begin
    if (smp_valid_o && smp_ready_i) begin
      n_tests++;
      assert (exp_q.size() > 0) else begin
        n_fail++;
        $error("FAIL sample_unexpected: observed idx %0d data 0x%0h expected none", smp_index_o, smp_data_o);
      end
      if (exp_q.size() > 0) chk("sample", {28'd0, smp_last_o, smp_index_o, smp_data_o}, {28'd0, exp_q.pop_front()});
    end
    if (spr_access_o && spr_grant_i && spr_ack_i) begin
      if (spr_re_o) begin
        n_rd++;
        last_rd_addr = spr_addr_o;
      end
      if (spr_we_o) begin
        n_wr++;
        chk("clr_addr", {48'd0, spr_addr_o}, {48'd0, last_rd_addr});
        chk("clr_data", {32'd0, spr_dat_o}, 64'd0);
      end
    end
    if (busy_o && !busy_prev) rise_cyc.push_back(cyc);
    busy_prev = busy_o;
  end

  task automatic push_burst(input logic [31:0] base, input bit inc);
    for (int i = 0; i < 8; i++)
      exp_q.push_back({(i == 7), 3'(i), base + (inc ? 32'(i) : 32'd0)});
  endtask

  task automatic load_pccr(input logic [31:0] base);
    @(posedge clk); #1;
    load_base = base;
    load_req  = 1'b1;
    @(posedge clk); #1;
    load_req  = 1'b0;
  endtask

  task automatic pulse_trigger();
    @(posedge clk); #1;
    trigger_i = 1'b1;
    @(posedge clk); #1;
    trigger_i = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    repeat (3) @(negedge clk);
    while (busy_o && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 64'(n < 1000), 64'd1);
  endtask

  task automatic wait_drain(input string tag);
    int n = 0;
    repeat (3) @(negedge clk);
    while ((busy_o || smp_valid_o || exp_q.size() != 0) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 64'(n < 2000), 64'd1);
  endtask

  initial begin
    int rd0, wr0, cyc_en, base_i, nt;
    logic [15:0] a0;
    logic any_acc, any_val;

    // Reset state
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_access", 64'(spr_access_o), 64'd0);
    chk("rst_strobes", {62'd0, spr_we_o, spr_re_o}, 64'd0);
    chk("rst_addr", {48'd0, spr_addr_o}, 64'd0);
    chk("rst_dat", {32'd0, spr_dat_o}, 64'd0);
    chk("rst_smp", {27'd0, smp_valid_o, smp_last_o, smp_index_o, smp_data_o}, 64'd0);
    chk("rst_flags", {62'd0, skipped_o, busy_o}, 64'd0);

    // 1: plain burst, no clear
    load_pccr(32'h100);
    rd0 = n_rd;
    push_burst(32'h100, 1'b1);
    pulse_trigger();
    wait_drain("t1_done");
    chk("t1_reads", 64'(n_rd - rd0), 64'd8);
    chk("t1_writes", 64'(n_wr), 64'd0);

    // 2: clear on read, then re-read cleared counters
    wr0 = n_wr;
    @(posedge clk); #1 clear_on_read_i = 1'b1;
    push_burst(32'h100, 1'b1);
    pulse_trigger();
    @(posedge clk); #1 clear_on_read_i = 1'b0;
    wait_drain("t2_done");
    chk("t2_writes", 64'(n_wr - wr0), 64'd8);
    push_burst(32'h0, 1'b0);
    pulse_trigger();
    wait_drain("t2_reread_done");
    chk("t2_no_writes", 64'(n_wr - wr0), 64'd8);

    // 3: periodic sampling
    load_pccr(32'h200);
    for (int b = 0; b < 3; b++) push_burst(32'h200, 1'b1);
    base_i = rise_cyc.size();
    @(posedge clk); #1;
    period_i    = 32'd50;
    sample_en_i = 1'b1;
    cyc_en      = cyc;
    nt = 0;
    while (rise_cyc.size() < base_i + 3 && nt < 400) begin
      @(negedge clk);
      nt++;
    end
    chk("t3_bursts_seen", 64'(rise_cyc.size() >= base_i + 3), 64'd1);
    @(posedge clk); #1 sample_en_i = 1'b0;
    wait_drain("t3_done");
    if (rise_cyc.size() >= base_i + 3) begin
      chk("t3_first", 64'(rise_cyc[base_i] - cyc_en), 64'd53);
      chk("t3_period1", 64'(rise_cyc[base_i+1] - rise_cyc[base_i]), 64'd51);
      chk("t3_period2", 64'(rise_cyc[base_i+2] - rise_cyc[base_i+1]), 64'd51);
    end
    chk("t3_skipped", 64'(skipped_o), 64'd0);

    // 4: FIFO fills, third burst skipped
    load_pccr(32'h300);
    @(posedge clk); #1 smp_ready_i = 1'b0;
    push_burst(32'h300, 1'b1);
    push_burst(32'h300, 1'b1);
    pulse_trigger();
    wait_idle("t4_burst1");
    pulse_trigger();
    wait_idle("t4_burst2");
    chk("t4_not_skipped_yet", 64'(skipped_o), 64'd0);
    rd0 = n_rd;
    pulse_trigger();
    repeat (10) @(negedge clk);
    chk("t4_no_spr", 64'(n_rd - rd0), 64'd0);
    chk("t4_skipped", 64'(skipped_o), 64'd1);
    chk("t4_idle", 64'(busy_o), 64'd0);
    chk("t4_valid", 64'(smp_valid_o), 64'd1);
    @(posedge clk); #1 smp_ready_i = 1'b1;
    wait_drain("t4_done");

    // 5: grant withheld, delayed ack
    load_pccr(32'h500);
    @(posedge clk); #1;
    ack_delay   = 3;
    spr_grant_i = 1'b0;
    push_burst(32'h500, 1'b1);
    pulse_trigger();
    nt = 0;
    while (!spr_access_o && nt < 20) begin
      @(negedge clk);
      nt++;
    end
    chk("t5_access_seen", 64'(spr_access_o), 64'd1);
    a0 = spr_addr_o;
    chk("t5_addr0", {48'd0, a0}, {48'd0, BASE});
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("t5_addr_hold", {48'd0, spr_addr_o}, {48'd0, a0});
      chk("t5_re_hold", {62'd0, spr_access_o, spr_re_o}, 64'd3);
    end
    @(posedge clk); #1 spr_grant_i = 1'b1;
    wait_drain("t5_done");
    chk("t5_skipped_sticky", 64'(skipped_o), 64'd1);

    // 6: reset during the clear write of counter 3
    @(posedge clk); #1;
    ack_delay       = 0;
    smp_ready_i     = 1'b0;
    clear_on_read_i = 1'b1;
    pulse_trigger();
    nt = 0;
    while (!(spr_we_o && spr_addr_o == BASE + 16'd3) && nt < 100) begin
      @(negedge clk);
      nt++;
    end
    chk("t6_clr3_seen", 64'(spr_we_o), 64'd1);
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    chk("t6_spr", {44'd0, spr_access_o, spr_we_o, spr_re_o, spr_addr_o}, 64'd0);
    chk("t6_smp", {27'd0, smp_valid_o, smp_last_o, smp_index_o, smp_data_o}, 64'd0);
    chk("t6_flags", {62'd0, skipped_o, busy_o}, 64'd0);
    @(posedge clk); #1;
    rst             = 1'b0;
    smp_ready_i     = 1'b1;
    clear_on_read_i = 1'b0;
    any_acc = 1'b0;
    any_val = 1'b0;
    repeat (10) begin
      @(negedge clk);
      any_acc |= spr_access_o;
      any_val |= smp_valid_o;
    end
    chk("t6_no_access", 64'(any_acc), 64'd0);
    chk("t6_fifo_flushed", 64'(any_val), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
